dff_link_serializer: RTL



---
 rtl/dff_link_pkg.sv | 26 ++
 rtl/dff_link_serializer.sv | 131 +++++++++++++
 2 files changed

// File: rtl/dff_link_pkg.sv
// Shared types and constants for the DFF link stimulus path.
//   state_e        : serializer FSM states (PARITY is only reachable when
//                    DFF_LINK_SERIALIZER_PARITY_EN is defined)
//   DEF_IDLE_LEVEL : default serial line level when idle / stop bit
//   FRAME_OVH      : framing bits per word without parity (start + stop)
//   FRAME_OVH_PAR  : framing bits per word with parity (start + parity + stop)
package dff_link_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    localparam logic        DEF_IDLE_LEVEL = 1'b1;
    localparam int unsigned FRAME_OVH      = 2;
    localparam int unsigned FRAME_OVH_PAR  = 3;

    // Total serial cycles for one word of width w.
    function automatic int unsigned frame_len(input int unsigned w, input bit par_en);
        return w + (par_en ? FRAME_OVH_PAR : FRAME_OVH);
    endfunction

endpackage

// File: rtl/dff_link_serializer.sv
// Parallel-to-serial transmitter feeding the DFF link delay chain input.
// Frame: start bit (~IDLE_LEVEL), payload LSB first, optional even parity,
// stop bit (IDLE_LEVEL). One bit per CLK.
//
// Optional feature: define DFF_LINK_SERIALIZER_PARITY_EN to insert a parity
// bit (XOR of the captured word) between the payload MSB and the stop bit.
//
// Ports:
//   CLK          clock, all logic on posedge
//   RST          synchronous active-high reset
//   load_valid   upstream word present on load_data
//   load_data    word to serialize (DATA_WIDTH bits)
//   load_ready   combinational: word accepted this cycle (IDLE or STOP)
//   output_data  registered serial stream
//   frame_active high from start bit through stop bit
//   frame_done   one-cycle pulse during the stop bit
module dff_link_serializer
    import dff_link_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic        IDLE_LEVEL = DEF_IDLE_LEVEL
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic                  output_data,
    output logic                  frame_active,
    output logic                  frame_done
);

    localparam int unsigned     CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    state_e                r_state;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_out;
    logic                  r_active;
    logic                  r_done;
`ifdef DFF_LINK_SERIALIZER_PARITY_EN
    logic                  r_parity;
`endif

    logic w_transfer;

    // STOP also accepts so that a held load_valid gives gapless frames.
    assign load_ready = (r_state == ST_IDLE) || (r_state == ST_STOP);
    assign w_transfer = load_valid && load_ready;

    // FSM, datapath and registered outputs; r_out always holds the bit
    // belonging to the state being entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_shreg  <= '0;
            r_cnt    <= '0;
            r_out    <= IDLE_LEVEL;
            r_active <= 1'b0;
            r_done   <= 1'b0;
`ifdef DFF_LINK_SERIALIZER_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_STOP: begin
                    if (w_transfer) begin
                        r_state  <= ST_START;
                        r_shreg  <= load_data;
                        r_cnt    <= '0;
                        r_out    <= ~IDLE_LEVEL;
                        r_active <= 1'b1;
`ifdef DFF_LINK_SERIALIZER_PARITY_EN
                        r_parity <= ^load_data;
`endif
                    end else begin
                        r_state  <= ST_IDLE;
                        r_out    <= IDLE_LEVEL;
                        r_active <= 1'b0;
                    end
                end

                ST_START: begin
                    r_state <= ST_SHIFT;
                    r_out   <= r_shreg[0];
                    r_shreg <= r_shreg >> 1;
                    r_cnt   <= '0;
                end

                // r_cnt is the index of the payload bit currently on the line.
                ST_SHIFT: begin
                    if (r_cnt == CNT_LAST) begin
`ifdef DFF_LINK_SERIALIZER_PARITY_EN
                        r_state <= ST_PARITY;
                        r_out   <= r_parity;
`else
                        r_state <= ST_STOP;
                        r_out   <= IDLE_LEVEL;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_out   <= r_shreg[0];
                        r_shreg <= r_shreg >> 1;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end
                end

`ifdef DFF_LINK_SERIALIZER_PARITY_EN
                ST_PARITY: begin
                    r_state <= ST_STOP;
                    r_out   <= IDLE_LEVEL;
                    r_done  <= 1'b1;
                end
`endif

                default: begin
                    r_state  <= ST_IDLE;
                    r_out    <= IDLE_LEVEL;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign output_data  = r_out;
    assign frame_active = r_active;
    assign frame_done   = r_done;

endmodule
